// File: rtl/mem_result_checker.sv
// End-of-program self-check: waits for END_PC, drains the pipeline, then compares N_CHECKS data-memory
// words against EXP_TABLE (entry i = {mask[31:0], exp[31:0]} at bits [64*i +: 64]) and reports pass/fail.

module mem_result_checker #(
    parameter int unsigned N_CHECKS           = 127,
    parameter int unsigned BASE_W             = 0,
    parameter logic [31:0] END_PC             = 32'h680,
    parameter int unsigned DRAIN_CLKS         = 20,
    parameter int unsigned TIMEOUT_CLKS       = 100000,
    parameter logic [64*N_CHECKS-1:0] EXP_TABLE = '0,
    localparam int unsigned CW = $clog2(N_CHECKS + 1),
    localparam int unsigned IW = (N_CHECKS > 1) ? $clog2(N_CHECKS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   pc,
    output logic [31:0]   chk_addr,
    input  logic [31:0]   chk_rd,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [CW-1:0] err_cnt,
    output logic [IW-1:0] first_err_idx,
    output logic [31:0]   first_err_got
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRAIN = 3'd1;
    localparam logic [2:0] S_SCAN  = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int unsigned    DW         = (DRAIN_CLKS > 0) ? $clog2(DRAIN_CLKS + 1) : 1;
    localparam logic [DW-1:0]  DRAIN_LAST = DW'(DRAIN_CLKS);
    localparam logic [IW-1:0]  IDX_LAST   = IW'(N_CHECKS - 1);
    localparam logic [31:0]    BASE_ADDR  = 32'(BASE_W);

    logic [2:0]    state_q,    state_d;
    logic [DW-1:0] cnt_q,      cnt_d;
    logic [31:0]   tout_q,     tout_d;
    logic [IW-1:0] idx_q,      idx_d;
    logic [31:0]   addr_q,     addr_d;
    logic          cmpVld_q,   cmpVld_d;
    logic [IW-1:0] cmpIdx_q,   cmpIdx_d;
    logic [CW-1:0] err_q,      err_d;
    logic [IW-1:0] firstIdx_q, firstIdx_d;
    logic [31:0]   firstGot_q, firstGot_d;
    logic          done_q,     done_d;
    logic          timeout_q,  timeout_d;

    logic [63:0]   entry;
    logic          mismatch;

    // The compare stage trails the address stage by one clock to line up with the synchronous read.
    always_comb begin
        entry    = EXP_TABLE[32'(cmpIdx_q) * 32'd64 +: 64];
        mismatch = |((chk_rd ^ entry[31:0]) & entry[63:32]);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tout_d     = tout_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        cmpVld_d   = 1'b0;
        cmpIdx_d   = cmpIdx_q;
        err_d      = err_q;
        firstIdx_d = firstIdx_q;
        firstGot_d = firstGot_q;
        done_d     = done_q;
        timeout_d  = timeout_q;

        if (cmpVld_q && mismatch) begin
            if (err_q == '0) begin
                firstIdx_d = cmpIdx_q;
                firstGot_d = chk_rd;
            end
            if (err_q != '1) begin
                err_d = err_q + CW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                tout_d = tout_q + 32'd1;
                // Trigger is tested first so it wins over a timeout on the same edge.
                if (pc == END_PC) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    addr_d  = BASE_ADDR;
                    state_d = (DRAIN_CLKS == 0) ? S_SCAN : S_DRAIN;
                end else if ((TIMEOUT_CLKS != 0) && (tout_d == TIMEOUT_CLKS)) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + DW'(1);
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                cmpVld_d = 1'b1;
                cmpIdx_d = idx_q;
                if (idx_q == IDX_LAST) begin
                    state_d = S_FLUSH;
                end else begin
                    idx_d  = idx_q + IW'(1);
                    addr_d = BASE_ADDR + 32'(idx_q) + 32'd1;
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_DONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            tout_q     <= '0;
            idx_q      <= '0;
            addr_q     <= BASE_ADDR;
            cmpVld_q   <= 1'b0;
            cmpIdx_q   <= '0;
            err_q      <= '0;
            firstIdx_q <= '0;
            firstGot_q <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tout_q     <= tout_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            cmpVld_q   <= cmpVld_d;
            cmpIdx_q   <= cmpIdx_d;
            err_q      <= err_d;
            firstIdx_q <= firstIdx_d;
            firstGot_q <= firstGot_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    assign chk_addr      = addr_q;
    assign done          = done_q;
    assign pass          = done_q && (err_q == '0) && !timeout_q;
    assign timeout       = timeout_q;
    assign err_cnt       = err_q;
    assign first_err_idx = firstIdx_q;
    assign first_err_got = firstGot_q;

endmodule
